base_rr_arb_mux: RTL

// - Round-robin arbiter plus registered mux: shares one downstream channel among `ways` requesters.
// - Each requester and the output use a valid/ready handshake; transfers may be multi-beat packets (last flag).
// - Sits in front of any single-consumer datapath (bus, buffer write port) that several units must drive.
// - Output is fully registered: one-entry output stage, no combinational path from o_d to i_d.

---
 rtl/base_pkg.sv | 14 +
 rtl/base_rr_pick.sv | 32 +++
 rtl/base_rr_arb_mux.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/base_pkg.sv
// Shared arbiter types and helpers. Round-robin blocks import this package.
package base_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Modular increment that wraps at n-1 explicitly, so non-power-of-2 counts never reach unused codes.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/base_rr_pick.sv
// Combinational rotating-priority picker: the first set req bit at or after ptr wins, wrapping at ways-1.
module base_rr_pick #(
    parameter int ways = 2,
    parameter int selw = 1
) (
    input  logic [ways-1:0] req,
    input  logic [selw-1:0] ptr,
    output logic [ways-1:0] gnt,
    output logic [selw-1:0] gnt_idx,
    output logic            any
);

    always_comb begin
        int k;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = 0;
        for (int i = 0; i < ways; i++) begin
            k = int'(ptr) + i;
            if (k >= ways) begin
                k = k - ways;
            end
            if (!any && req[k]) begin
                any     = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = selw'(k);
            end
        end
    end

endmodule

// File: rtl/base_rr_arb_mux.sv
// Round-robin arbiter with packet locking in front of a one-entry registered output stage.
// A requester that starts a multi-beat packet keeps the channel until its last beat is accepted.
module base_rr_arb_mux
    import base_pkg::*;
#(
    parameter int ways  = 2,
    parameter int width = 1,
    parameter int selw  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ways-1:0]       i_v,
    output logic [ways-1:0]       i_r,
    input  logic [ways*width-1:0] i_d,
    input  logic [ways-1:0]       i_l,
    output logic                  o_v,
    input  logic                  o_r,
    output logic [width-1:0]      o_d,
    output logic                  o_l,
    output logic [selw-1:0]       o_sel
);

    generate
        if (selw != $clog2(ways)) begin : g_bad_selw
            $error("base_rr_arb_mux: selw must equal $clog2(ways)");
        end
        if (ways < 2) begin : g_bad_ways
            $error("base_rr_arb_mux: ways must be at least 2");
        end
    endgenerate

    arb_state_t        state_q, state_d;
    logic [selw-1:0]   ptr_q, ptr_d;
    logic [selw-1:0]   lock_q, lock_d;
    logic              o_v_q, o_v_d;
    logic [width-1:0]  o_d_q, o_d_d;
    logic              o_l_q, o_l_d;
    logic [selw-1:0]   o_sel_q, o_sel_d;

    logic              free;
    logic [ways-1:0]   pick_req;
    logic [selw-1:0]   pick_ptr;
    logic [ways-1:0]   gnt;
    logic [selw-1:0]   gnt_idx;
    logic              any;
    logic              accept;
    logic [width-1:0]  beat_d;
    logic              beat_l;
    logic [width-1:0]  beat_slice [ways];

    assign free = ~o_v_q | o_r;

    // While locked, only the owner is presented to the picker; starting the search at the owner makes it win.
    always_comb begin
        pick_req = i_v;
        pick_ptr = ptr_q;
        if (state_q == LOCK) begin
            pick_req         = '0;
            pick_req[lock_q] = i_v[lock_q];
            pick_ptr         = lock_q;
        end
    end

    base_rr_pick #(
        .ways (ways),
        .selw (selw)
    ) u_pick (
        .req     (pick_req),
        .ptr     (pick_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign accept = any & free & ~reset;
    assign i_r    = accept ? gnt : '0;

    // AND-OR mux: the grant is one-hot, so OR-ing the masked slices needs no priority chain.
    genvar gi;
    generate
        for (gi = 0; gi < ways; gi++) begin : g_slice
            assign beat_slice[gi] = i_d[gi*width +: width] & {width{gnt[gi]}};
        end
    endgenerate

    always_comb begin
        beat_d = '0;
        for (int k = 0; k < ways; k++) begin
            beat_d = beat_d | beat_slice[k];
        end
        beat_l = |(i_l & gnt);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        o_v_d   = o_v_q;
        o_d_d   = o_d_q;
        o_l_d   = o_l_q;
        o_sel_d = o_sel_q;
        if (accept) begin
            o_v_d   = 1'b1;
            o_d_d   = beat_d;
            o_l_d   = beat_l;
            o_sel_d = gnt_idx;
            if (beat_l) begin
                state_d = IDLE;
                ptr_d   = selw'(rr_next(int'(gnt_idx), ways));
            end else begin
                state_d = LOCK;
                lock_d  = gnt_idx;
            end
        end else if (o_r) begin
            o_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            o_v_q   <= 1'b0;
            o_d_q   <= '0;
            o_l_q   <= 1'b0;
            o_sel_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            o_v_q   <= o_v_d;
            o_d_q   <= o_d_d;
            o_l_q   <= o_l_d;
            o_sel_q <= o_sel_d;
        end
    end

    assign o_v   = o_v_q;
    assign o_d   = o_d_q;
    assign o_l   = o_l_q;
    assign o_sel = o_sel_q;

endmodule
